rca_writeback_unit: RTL and testbench

- Retirement end of the RCA result path: buffers completed RCA results and retires one ID per cycle to the ID management block (rca_id_retiring / rca_retired).
- Uses the per-port rd addresses and current rd-owner IDs returned for that ID to drive the multi-port register-file write and inuse-clear signals.
- Sits between the RCA result interface and the register file, alongside the standard commit ports.

---
 rtl/rca_writeback_unit.sv | 149 ++++++++++++++
 tb/tb_rca_writeback_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_writeback_unit.sv
// Retirement end of the RCA result path: buffers completed results, retires one
// ID per cycle and drives the multi-port register-file write / inuse-clear stage.
module rca_writeback_unit #(
  parameter int NUM_WRITE_PORTS = 3,
  parameter int ID_W            = 3,
  parameter int FIFO_DEPTH      = 4,
  parameter int XLEN            = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rca_result_valid,
  output logic                              rca_result_ready,
  input  logic [ID_W-1:0]                   rca_result_id,
  input  logic [NUM_WRITE_PORTS-1:0]        rca_result_we,
  input  logic [NUM_WRITE_PORTS*XLEN-1:0]   rca_result_data,
  input  logic                              wb_hold,
  output logic [ID_W-1:0]                   rca_id_retiring,
  output logic                              rca_retired,
  input  logic [NUM_WRITE_PORTS*5-1:0]      rca_retired_rd_addrs,
  input  logic [NUM_WRITE_PORTS*ID_W-1:0]   rca_id_for_rds,
  output logic [NUM_WRITE_PORTS-1:0]        rf_wr_en,
  output logic [NUM_WRITE_PORTS*5-1:0]      rf_wr_addr,
  output logic [NUM_WRITE_PORTS*XLEN-1:0]   rf_wr_data,
  output logic [NUM_WRITE_PORTS-1:0]        rf_inuse_clr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [ID_W-1:0]                 fifo_id_q   [FIFO_DEPTH];
  logic [NUM_WRITE_PORTS-1:0]      fifo_we_q   [FIFO_DEPTH];
  logic [NUM_WRITE_PORTS*XLEN-1:0] fifo_data_q [FIFO_DEPTH];

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

  logic [NUM_WRITE_PORTS-1:0]      wr_en_q;
  logic [NUM_WRITE_PORTS-1:0]      inuse_clr_q;
  logic [NUM_WRITE_PORTS*5-1:0]    wr_addr_q;
  logic [NUM_WRITE_PORTS*XLEN-1:0] wr_data_q;

  logic                            push_s;
  logic                            not_empty_s;
  logic [ID_W-1:0]                 head_id_s;
  logic [NUM_WRITE_PORTS-1:0]      head_we_s;
  logic [NUM_WRITE_PORTS*XLEN-1:0] head_data_s;
  logic [NUM_WRITE_PORTS-1:0]      en_s;
  logic [NUM_WRITE_PORTS-1:0]      clr_s;

  // Ready is a pure function of occupancy so a full buffer never accepts, even on a pop.
  assign not_empty_s      = (count_q != {CNT_W{1'b0}});
  assign rca_result_ready = rst & (count_q != CNT_FULL);
  assign push_s           = rca_result_valid & rca_result_ready;

  assign head_id_s   = fifo_id_q[rd_ptr_q];
  assign head_we_s   = fifo_we_q[rd_ptr_q];
  assign head_data_s = fifo_data_q[rd_ptr_q];

  assign rca_retired     = not_empty_s & ~wb_hold;
  assign rca_id_retiring = not_empty_s ? head_id_s : {ID_W{1'b0}};

  assign rf_wr_en     = wr_en_q;
  assign rf_inuse_clr = inuse_clr_q;
  assign rf_wr_addr   = wr_addr_q;
  assign rf_wr_data   = wr_data_q;

  // Per-port write qualification: x0 never written, highest port wins a duplicate rd.
  always_comb begin
    en_s  = {NUM_WRITE_PORTS{1'b0}};
    clr_s = {NUM_WRITE_PORTS{1'b0}};
    for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
      en_s[i] = head_we_s[i] & (rca_retired_rd_addrs[i*5 +: 5] != 5'd0);
      for (int j = i + 1; j < NUM_WRITE_PORTS; j++) begin
        if (head_we_s[j] && (rca_retired_rd_addrs[j*5 +: 5] == rca_retired_rd_addrs[i*5 +: 5])) begin
          en_s[i] = 1'b0;
        end else begin
          en_s[i] = en_s[i];
        end
      end
      clr_s[i] = en_s[i] & (rca_id_for_rds[i*ID_W +: ID_W] == head_id_s);
    end
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rca_retired) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, rca_retired})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control state and write stage; reset drops buffered entries and any pending write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q     <= {CNT_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      wr_ptr_q    <= {PTR_W{1'b0}};
      wr_en_q     <= {NUM_WRITE_PORTS{1'b0}};
      inuse_clr_q <= {NUM_WRITE_PORTS{1'b0}};
      wr_addr_q   <= {(NUM_WRITE_PORTS*5){1'b0}};
      wr_data_q   <= {(NUM_WRITE_PORTS*XLEN){1'b0}};
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      if (rca_retired) begin
        wr_en_q     <= en_s;
        inuse_clr_q <= clr_s;
        wr_addr_q   <= rca_retired_rd_addrs;
        wr_data_q   <= head_data_s;
      end else begin
        wr_en_q     <= {NUM_WRITE_PORTS{1'b0}};
        inuse_clr_q <= {NUM_WRITE_PORTS{1'b0}};
      end
    end
  end

  // Payload storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_id_q[wr_ptr_q]   <= rca_result_id;
      fifo_we_q[wr_ptr_q]   <= rca_result_we;
      fifo_data_q[wr_ptr_q] <= rca_result_data;
    end else begin
      fifo_id_q[wr_ptr_q]   <= fifo_id_q[wr_ptr_q];
      fifo_we_q[wr_ptr_q]   <= fifo_we_q[wr_ptr_q];
      fifo_data_q[wr_ptr_q] <= fifo_data_q[wr_ptr_q];
    end
  end

endmodule

// File: tb/tb_rca_writeback_unit.sv
// Randomized and directed bench for rca_writeback_unit, checked every cycle
// against a queue-based model of the retire and write-stage rules.
module tb_rca_writeback_unit;

  localparam int NP = 3;
  localparam int IW = 3;
  localparam int XL = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid;
  logic            ready;
  logic [IW-1:0]   rid;
  logic [NP-1:0]   rwe;
  logic [NP*XL-1:0] rdata;
  logic            hold;
  logic [IW-1:0]   id_ret;
  logic            retired;
  logic [NP*5-1:0] rd_addrs;
  logic [NP*IW-1:0] id_for;
  logic [NP-1:0]   wr_en;
  logic [NP*5-1:0] wr_addr;
  logic [NP*XL-1:0] wr_data;
  logic [NP-1:0]   clr;

  // ID-management side tables: rd per port per ID, and current owner of that rd.
  logic [4:0]      rd_tab  [8][NP];
  logic [IW-1:0]   own_tab [8][NP];

  // Behavioural model state.
  logic [IW-1:0]    q_id   [$];
  logic [NP-1:0]    q_we   [$];
  logic [NP*XL-1:0] q_data [$];
  logic [NP-1:0]    e_en, e_clr;
  logic [NP*5-1:0]  e_addr;
  logic [NP*XL-1:0] e_data;
  bit               armed = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rca_writeback_unit #(
    .NUM_WRITE_PORTS(NP), .ID_W(IW), .FIFO_DEPTH(DEPTH), .XLEN(XL)
  ) dut (
    .clk(clk), .rst(rst),
    .rca_result_valid(valid), .rca_result_ready(ready),
    .rca_result_id(rid), .rca_result_we(rwe), .rca_result_data(rdata),
    .wb_hold(hold),
    .rca_id_retiring(id_ret), .rca_retired(retired),
    .rca_retired_rd_addrs(rd_addrs), .rca_id_for_rds(id_for),
    .rf_wr_en(wr_en), .rf_wr_addr(wr_addr), .rf_wr_data(wr_data),
    .rf_inuse_clr(clr)
  );

  always_comb begin
    rd_addrs = '0;
    id_for   = '0;
    for (int i = 0; i < NP; i++) begin
      rd_addrs[i*5 +: 5]   = rd_tab[id_ret][i];
      id_for[i*IW +: IW]   = own_tab[id_ret][i];
    end
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_compare();
    logic exp_ret;
    exp_ret = (q_id.size() != 0) && !hold;
    check("ready", 128'(ready), 128'(rst && (q_id.size() != DEPTH)));
    if (armed) begin
      check("retired", 128'(retired), 128'(exp_ret));
      check("id_retiring", 128'(id_ret), 128'((q_id.size() != 0) ? q_id[0] : 3'd0));
      check("wr_en", 128'(wr_en), 128'(e_en));
      check("inuse_clr", 128'(clr), 128'(e_clr));
      check("wr_addr", 128'(wr_addr), 128'(e_addr));
      check("wr_data", 128'(wr_data), 128'(e_data));
    end
  endtask

  task automatic model_update();
    bit do_ret, do_push;
    bit claimed [32];
    logic [IW-1:0] h;
    logic [NP-1:0] w;
    logic [4:0] rd;
    if (!rst) begin
      q_id.delete(); q_we.delete(); q_data.delete();
      e_en = '0; e_clr = '0; e_addr = '0; e_data = '0;
      armed = 1'b1;
    end else begin
      do_ret  = (q_id.size() != 0) && !hold;
      do_push = valid && (q_id.size() != DEPTH);
      if (do_ret) begin
        h = q_id[0];
        w = q_we[0];
        foreach (claimed[k]) claimed[k] = 1'b0;
        e_en = '0; e_clr = '0;
        // Walk from the highest port down: first claimant of an rd wins it.
        for (int i = NP - 1; i >= 0; i--) begin
          rd = rd_tab[h][i];
          e_addr[i*5 +: 5] = rd;
          if (w[i] && rd != 5'd0) begin
            if (!claimed[rd]) begin
              e_en[i] = 1'b1;
              e_clr[i] = (own_tab[h][i] == h);
            end
            claimed[rd] = 1'b1;
          end
        end
        e_data = q_data[0];
        void'(q_id.pop_front()); void'(q_we.pop_front()); void'(q_data.pop_front());
      end else begin
        e_en = '0;
        e_clr = '0;
      end
      if (do_push) begin
        q_id.push_back(rid); q_we.push_back(rwe); q_data.push_back(rdata);
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_compare();
  endtask

  task automatic to_next();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    at_neg();
    to_next();
  endtask

  task automatic offer(input bit v, input logic [IW-1:0] id, input logic [NP-1:0] we,
                       input logic [NP*XL-1:0] d);
    valid = v; rid = id; rwe = we; rdata = d;
  endtask

  initial begin
    for (int a = 0; a < 8; a++) begin
      for (int p = 0; p < NP; p++) begin
        rd_tab[a][p] = 5'd0;
        own_tab[a][p] = 3'd0;
      end
    end
    rst = 1'b0; hold = 1'b0;
    offer(1'b0, 3'd0, 3'b000, '0);
    cycle();
    cycle();
    rst = 1'b1;
    at_neg();
    check("rst_ready", 128'(ready), 128'(1'b1));
    check("rst_retired", 128'(retired), 128'(1'b0));
    check("rst_wr_en", 128'(wr_en), 128'(3'b000));
    to_next();

    // Single result, then ownership lost on port 0.
    for (int t = 0; t < 2; t++) begin
      rd_tab[3][0] = 5'd5; rd_tab[3][1] = 5'd7; rd_tab[3][2] = 5'd0;
      own_tab[3][0] = (t == 0) ? 3'd3 : 3'd6; own_tab[3][1] = 3'd3; own_tab[3][2] = 3'd0;
      offer(1'b1, 3'd3, 3'b011, {32'h0, 32'h22, 32'h11});
      cycle();
      offer(1'b0, 3'd0, 3'b000, '0);
      at_neg();
      check("single_retired", 128'(retired), 128'(1'b1));
      check("single_id", 128'(id_ret), 128'(3'd3));
      to_next();
      at_neg();
      check("single_wr_en", 128'(wr_en), 128'(3'b011));
      check("single_addr", 128'(wr_addr[9:0]), 128'({5'd7, 5'd5}));
      check("single_data", 128'(wr_data[63:0]), 128'({32'h22, 32'h11}));
      check("single_clr", 128'(clr), 128'((t == 0) ? 3'b011 : 3'b010));
      to_next();
    end

    // Duplicate rd and x0.
    rd_tab[4][0] = 5'd9; rd_tab[4][1] = 5'd9; rd_tab[4][2] = 5'd0;
    own_tab[4][0] = 3'd4; own_tab[4][1] = 3'd4; own_tab[4][2] = 3'd4;
    offer(1'b1, 3'd4, 3'b111, {32'h33, 32'h22, 32'h11});
    cycle();
    offer(1'b0, 3'd0, 3'b000, '0);
    cycle();
    at_neg();
    check("dup_wr_en", 128'(wr_en), 128'(3'b010));
    check("dup_addr", 128'(wr_addr[9:5]), 128'(5'd9));
    check("dup_data", 128'(wr_data[63:32]), 128'(32'h22));
    to_next();

    // Fill under hold, then release with a fifth result waiting.
    hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rd_tab[k][0] = 5'(k + 1); own_tab[k][0] = 3'(k);
      offer(1'b1, 3'(k), 3'b001, {64'h0, 32'h100 + 32'(k)});
      cycle();
    end
    offer(1'b0, 3'd0, 3'b000, '0);
    at_neg();
    check("full_ready", 128'(ready), 128'(1'b0));
    check("hold_retired", 128'(retired), 128'(1'b0));
    to_next();
    hold = 1'b0;
    offer(1'b1, 3'd5, 3'b001, {64'h0, 32'h555});
    at_neg();
    check("release_retired", 128'(retired), 128'(1'b1));
    check("release_id", 128'(id_ret), 128'(3'd0));
    check("release_ready", 128'(ready), 128'(1'b0));
    to_next();
    at_neg();
    check("after_pop_ready", 128'(ready), 128'(1'b1));
    check("after_pop_id", 128'(id_ret), 128'(3'd1));
    to_next();
    offer(1'b0, 3'd0, 3'b000, '0);
    for (int k = 0; k < 6; k++) cycle();

    // Back-to-back streaming with ID wrap.
    for (int k = 0; k < 9; k++) begin
      offer(1'b1, 3'(k % 8), 3'($urandom_range(0, 7)), {$urandom, $urandom, $urandom});
      cycle();
    end
    offer(1'b0, 3'd0, 3'b000, '0);
    for (int k = 0; k < 3; k++) cycle();

    // Reset with three entries buffered.
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      offer(1'b1, 3'(k + 2), 3'b111, {$urandom, $urandom, $urandom});
      cycle();
    end
    offer(1'b0, 3'd0, 3'b000, '0);
    rst = 1'b0;
    at_neg();
    check("midrst_ready", 128'(ready), 128'(1'b0));
    to_next();
    rst = 1'b1; hold = 1'b0;
    at_neg();
    check("postrst_ready", 128'(ready), 128'(1'b1));
    check("postrst_retired", 128'(retired), 128'(1'b0));
    check("postrst_wr_en", 128'(wr_en), 128'(3'b000));
    to_next();

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      for (int a = 0; a < 8; a++) begin
        for (int p = 0; p < NP; p++) begin
          rd_tab[a][p] = 5'($urandom_range(0, 3));
          own_tab[a][p] = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'(a);
        end
      end
      rst  = ($urandom_range(0, 63) != 0);
      hold = ($urandom_range(0, 3) == 0);
      offer($urandom_range(0, 2) != 0, 3'($urandom), 3'($urandom), {$urandom, $urandom, $urandom});
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
